// File: rtl/block_mem_arbiter_pkg.sv
// rtl/block_mem_arbiter_pkg.sv - shared widths and bus/tag types for the block memory arbiter
package block_mem_arbiter_pkg;

    localparam int BUS_WIDTH = 16;

    typedef struct packed {
        logic id;
        logic rw;
    } tag_t;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0] data;
        logic                 rw;
    } bus_req_t;

endpackage

// File: rtl/block_mem_arbiter_tag_fifo.sv
// rtl/block_mem_arbiter_tag_fifo.sv - in-order FIFO of outstanding transaction tags
module block_mem_arbiter_tag_fifo
    import block_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic pop_i,
    output tag_t pop_tag_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    tag_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign pop_tag_o = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
    end

endmodule

// File: rtl/block_mem_arbiter.sv
// rtl/block_mem_arbiter.sv - two-requester round-robin memory arbiter; BLOCK_MEM_ARBITER_STATS_EN adds grant counters
module block_mem_arbiter
    import block_mem_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] req0_addr,
    input  logic [BUS_WIDTH-1:0] req0_data,
    input  logic                 req0_rw,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    output logic [BUS_WIDTH-1:0] rsp0_data,
    output logic                 rsp0_rw,
    output logic                 rsp0_valid,
    input  logic [BUS_WIDTH-1:0] req1_addr,
    input  logic [BUS_WIDTH-1:0] req1_data,
    input  logic                 req1_rw,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [BUS_WIDTH-1:0] rsp1_data,
    output logic                 rsp1_rw,
    output logic                 rsp1_valid,
    output logic [BUS_WIDTH-1:0] mem_addr_o,
    output logic [BUS_WIDTH-1:0] mem_data_o,
    output logic                 mem_rw_o,
    output logic                 mem_valid_o,
    input  logic [BUS_WIDTH-1:0] mem_addr_i,
    input  logic [BUS_WIDTH-1:0] mem_data_i,
    input  logic                 mem_rw_i,
    input  logic                 mem_valid_i,
    output logic                 err_o
`ifdef BLOCK_MEM_ARBITER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat0_o,
    output logic [15:0]          stat1_o
`endif
);

    logic     full, empty, grant0, grant1, push, pop;
    logic     last_q, last_d;
    tag_t     push_tag, head_tag;
    bus_req_t mem_q, mem_d;
    logic     mem_valid_q;
    logic [BUS_WIDTH-1:0] rsp0_data_q, rsp1_data_q;
    logic     rsp0_rw_q, rsp1_rw_q, rsp0_valid_q, rsp1_valid_q;
    logic     err_q;
    logic     unused_mem_fields;

    // Responses are matched purely by order; returned address/rw are not checked.
    assign unused_mem_fields = ^{mem_addr_i, mem_rw_i};

    always_comb begin
        grant0   = req0_valid & ~full & (~req1_valid | last_q);
        grant1   = req1_valid & ~full & (~req0_valid | ~last_q);
        push     = grant0 | grant1;
        pop      = mem_valid_i & ~empty;
        push_tag = '{id: grant1, rw: (grant1 ? req1_rw : req0_rw)};
        last_d   = push ? grant1 : last_q;
        mem_d    = mem_q;
        if (grant1)      mem_d = '{addr: req1_addr, data: req1_data, rw: req1_rw};
        else if (grant0) mem_d = '{addr: req0_addr, data: req0_data, rw: req0_rw};
    end

    block_mem_arbiter_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_tag_i (push_tag),
        .pop_i      (pop),
        .pop_tag_o  (head_tag),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= 1'b1;
            mem_q        <= '0;
            mem_valid_q  <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_rw_q    <= 1'b0;
            rsp1_rw_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            last_q       <= last_d;
            mem_q        <= mem_d;
            mem_valid_q  <= push;
            rsp0_valid_q <= pop & ~head_tag.id;
            rsp1_valid_q <= pop & head_tag.id;
            if (pop & ~head_tag.id) begin
                rsp0_data_q <= mem_data_i;
                rsp0_rw_q   <= head_tag.rw;
            end
            if (pop & head_tag.id) begin
                rsp1_data_q <= mem_data_i;
                rsp1_rw_q   <= head_tag.rw;
            end
            if (mem_valid_i & empty) err_q <= 1'b1;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign mem_addr_o  = mem_q.addr;
    assign mem_data_o  = mem_q.data;
    assign mem_rw_o    = mem_q.rw;
    assign mem_valid_o = mem_valid_q;
    assign rsp0_data   = rsp0_data_q;
    assign rsp0_rw     = rsp0_rw_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_data   = rsp1_data_q;
    assign rsp1_rw     = rsp1_rw_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign err_o       = err_q;

`ifdef BLOCK_MEM_ARBITER_STATS_EN
    logic [15:0] stat0_q, stat1_q;

    // Clear wins over a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (stat_clr) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (grant0 && stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
            if (grant1 && stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
        end
    end

    assign stat0_o = stat0_q;
    assign stat1_o = stat1_q;
`endif

endmodule

// File: tb/tb_block_mem_arbiter.sv
// tb/tb_block_mem_arbiter.sv - scoreboard bench for block_mem_arbiter with a latency memory model
`timescale 1ns/1ps
module tb_block_mem_arbiter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req0_addr, req0_data, req1_addr, req1_data;
    logic        req0_rw, req0_valid, req0_ready, req1_rw, req1_valid, req1_ready;
    logic [15:0] rsp0_data, rsp1_data;
    logic        rsp0_rw, rsp0_valid, rsp1_rw, rsp1_valid;
    logic [15:0] mem_addr_o, mem_data_o, mem_addr_i, mem_data_i;
    logic        mem_rw_o, mem_valid_o, mem_rw_i, mem_valid_i;
    logic        err_o;
`ifdef BLOCK_MEM_ARBITER_STATS_EN
    logic        stat_clr;
    logic [15:0] stat0_o, stat1_o;
`endif

    always #5 clk = ~clk;

    block_mem_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_addr(req0_addr), .req0_data(req0_data), .req0_rw(req0_rw),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .rsp0_data(rsp0_data), .rsp0_rw(rsp0_rw), .rsp0_valid(rsp0_valid),
        .req1_addr(req1_addr), .req1_data(req1_data), .req1_rw(req1_rw),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .rsp1_data(rsp1_data), .rsp1_rw(rsp1_rw), .rsp1_valid(rsp1_valid),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_rw_o(mem_rw_o),
        .mem_valid_o(mem_valid_o),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_rw_i(mem_rw_i),
        .mem_valid_i(mem_valid_i),
        .err_o(err_o)
`ifdef BLOCK_MEM_ARBITER_STATS_EN
        , .stat_clr(stat_clr), .stat0_o(stat0_o), .stat1_o(stat1_o)
`endif
    );

    typedef struct { logic [15:0] addr; logic [15:0] data; logic rw; } mreq_t;
    typedef struct { logic id; logic rw; logic [15:0] data; } rsp_t;
    typedef struct { logic [15:0] data; int due; } pend_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    mreq_t exp_mem_q[$];
    rsp_t  exp_rsp_q[$];
    pend_t pend_q[$];
    int    grant_log[$];
    logic [15:0] ref_mem  [logic [15:0]];
    logic [15:0] phys_mem [logic [15:0]];

    int   outstanding;
    logic last_id, exp_err, prev_acc, prev_pop;
    int   acc_cnt [2];
    int   sm0, sm1;
    int   lat = 1;
    logic rand_lat = 1'b0, stall = 1'b0, rand_stall = 1'b0, spur = 1'b0;
    int   k0 = 0, k1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic reset_model();
        exp_mem_q.delete(); exp_rsp_q.delete(); pend_q.delete();
        outstanding = 0; last_id = 1'b1; exp_err = 1'b0;
        prev_acc = 1'b0; prev_pop = 1'b0; sm0 = 0; sm1 = 0;
    endtask

    always @(posedge clk) cyc++;

    // Reference: round-robin between valid requesters, at most DEPTH in flight, strict in-order completion.
    always @(negedge clk) begin : tracker
        logic full_m, win_valid, win, rw;
        logic [15:0] a, d, rd;
        if (!rst) begin
            chk("err_o", err_o, exp_err);
            chk("mem_valid_o", mem_valid_o, prev_acc);
            chk("rsp_strobe", rsp0_valid | rsp1_valid, prev_pop);
`ifdef BLOCK_MEM_ARBITER_STATS_EN
            chk("stat0_o", stat0_o, sm0);
            chk("stat1_o", stat1_o, sm1);
`endif
            full_m    = (outstanding >= DEPTH);
            win_valid = !full_m && (req0_valid || req1_valid);
            win       = (req0_valid && req1_valid) ? ~last_id : req1_valid;
            chk("req0_ready", req0_ready, win_valid && !win);
            chk("req1_ready", req1_ready, win_valid && win);
            prev_pop = mem_valid_i && (outstanding > 0);
            if (mem_valid_i && outstanding == 0) exp_err = 1'b1;
            prev_acc = win_valid;
`ifdef BLOCK_MEM_ARBITER_STATS_EN
            if (stat_clr) begin
                sm0 = 0; sm1 = 0;
            end else if (win_valid) begin
                if (!win && sm0 < 65535) sm0++;
                if (win && sm1 < 65535) sm1++;
            end
`endif
            if (win_valid) begin
                a  = win ? req1_addr : req0_addr;
                d  = win ? req1_data : req0_data;
                rw = win ? req1_rw : req0_rw;
                exp_mem_q.push_back('{addr: a, data: d, rw: rw});
                if (rw) begin
                    ref_mem[a] = d;
                    rd = d;
                end else begin
                    rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                end
                exp_rsp_q.push_back('{id: win, rw: rw, data: rd});
                last_id = win;
                outstanding++;
                acc_cnt[win]++;
                grant_log.push_back(int'(win));
            end
            if (prev_pop) outstanding--;
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT presents a memory request or a response.
    always @(negedge clk) begin : monitor
        mreq_t m;
        rsp_t  r;
        if (!rst) begin
            if (mem_valid_o) begin
                chk("mem_q_nonempty", exp_mem_q.size() != 0, 1'b1);
                if (exp_mem_q.size() != 0) begin
                    m = exp_mem_q.pop_front();
                    chk("mem_addr_o", mem_addr_o, m.addr);
                    chk("mem_data_o", mem_data_o, m.data);
                    chk("mem_rw_o", mem_rw_o, m.rw);
                end
            end
            chk("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
            if (rsp0_valid ^ rsp1_valid) begin
                chk("rsp_q_nonempty", exp_rsp_q.size() != 0, 1'b1);
                if (exp_rsp_q.size() != 0) begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_port", rsp1_valid, r.id);
                    chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, r.data);
                    chk("rsp_rw", rsp1_valid ? rsp1_rw : rsp0_rw, r.rw);
                end
            end
        end
    end

    // Memory model: in-order, fixed or random latency, optional stall.
    always @(negedge clk) begin
        logic [15:0] rd;
        int l;
        if (!rst && mem_valid_o) begin
            if (mem_rw_o) begin
                phys_mem[mem_addr_o] = mem_data_o;
                rd = mem_data_o;
            end else begin
                rd = phys_mem.exists(mem_addr_o) ? phys_mem[mem_addr_o] : dflt(mem_addr_o);
            end
            l = rand_lat ? int'($urandom_range(1, 6)) : lat;
            pend_q.push_back('{data: rd, due: cyc + l});
        end
    end

    always @(posedge clk) begin
        pend_t p;
        #1;
        mem_addr_i = 16'($urandom);
        mem_rw_i   = 1'($urandom);
        if (rst) begin
            mem_valid_i = 1'b0;
        end else if (spur) begin
            mem_valid_i = 1'b1;
            mem_data_i  = 16'($urandom);
        end else if (!stall && !(rand_stall && $urandom_range(0, 4) == 0) &&
                     pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            mem_valid_i = 1'b1;
            mem_data_i  = p.data;
        end else begin
            mem_valid_i = 1'b0;
        end
    end

    task automatic run_traffic(input int ncyc, input int p0, input int p1, input int mode);
        logic a0, a1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 99) < p0);
                req0_data  = 16'($urandom);
                if (mode == 1) begin
                    req0_addr = 16'(16'h0010 + k0);
                    req0_rw   = 1'b1;
                end else begin
                    req0_addr = 16'($urandom_range(0, 31));
                    req0_rw   = 1'($urandom_range(0, 1));
                end
                if (req0_valid) k0++;
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 99) < p1);
                req1_data  = 16'($urandom);
                if (mode == 1) begin
                    req1_addr = 16'(16'h0020 + k1);
                    req1_rw   = 1'b0;
                end else begin
                    req1_addr = 16'($urandom_range(0, 31));
                    req1_rw   = 1'($urandom_range(0, 1));
                end
                if (req1_valid) k1++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (exp_rsp_q.size() != 0 || pend_q.size() != 0); i++)
            @(negedge clk);
        @(negedge clk);
        chk("drain_rsp_q", exp_rsp_q.size(), 0);
        chk("drain_mem_q", exp_mem_q.size(), 0);
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_valid_o"}, mem_valid_o, 1'b0);
        chk({tag, "_mem_addr_o"}, mem_addr_o, 16'h0);
        chk({tag, "_mem_data_o"}, mem_data_o, 16'h0);
        chk({tag, "_mem_rw_o"}, mem_rw_o, 1'b0);
        chk({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        chk({tag, "_rsp_data"}, {rsp0_data, rsp1_data}, 32'h0);
        chk({tag, "_rsp_rw"}, {rsp0_rw, rsp1_rw}, 2'b00);
        chk({tag, "_err_o"}, err_o, 1'b0);
    endtask

    initial begin
        int s, base, seen;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        req0_data = 0; req1_data = 0; req0_rw = 0; req1_rw = 0;
        mem_valid_i = 0; mem_data_i = 0; mem_addr_i = 0; mem_rw_i = 0;
`ifdef BLOCK_MEM_ARBITER_STATS_EN
        stat_clr = 1'b0;
`endif
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        ref_mem[16'h0004] = 16'hBEEF;
        phys_mem[16'h0004] = 16'hBEEF;
        apply_reset();

        // Idle after reset, then a single read of 0x0004.
        repeat (10) @(negedge clk);
        check_all_zero("idle");
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 16'h0004; req0_rw = 1'b0; req0_data = 16'h1234;
        @(negedge clk);
        chk("first_req0_ready", req0_ready, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("first_mem_addr", mem_addr_o, 16'h0004);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                seen = 1;
                chk("first_rsp0_data", rsp0_data, 16'hBEEF);
            end
        end
        chk("first_rsp0_seen", seen, 1);
        drain();

        // Both requesters continuously valid: strict alternation starting with 0.
        apply_reset();
        s = grant_log.size();
        run_traffic(8, 100, 100, 1);
        drain();
        chk("alt_count", grant_log.size() - s, 8);
        for (int i = 0; i < 8; i++)
            if (s + i < grant_log.size()) chk($sformatf("alt_grant%0d", i), grant_log[s + i], i % 2);

        // req1 only with 4-cycle memory latency: no stall.
        lat = 4;
        base = acc_cnt[1];
        run_traffic(40, 0, 100, 0);
        chk("sustained_accepts", acc_cnt[1] - base, 40);
        drain();

        // Memory stalled: exactly DEPTH accepts, then recovery with no bypass when full.
        stall = 1'b1;
        base = acc_cnt[1];
        run_traffic(20, 0, 100, 0);
        chk("stall_accepts", acc_cnt[1] - base, DEPTH);
        stall = 1'b0;
        run_traffic(20, 0, 100, 0);
        drain();

        // Random mixed traffic with random latency and memory stalls.
        rand_lat = 1'b1;
        rand_stall = 1'b1;
        run_traffic(300, 60, 60, 0);
        rand_stall = 1'b0;
        drain();

        // Response with nothing outstanding sets the sticky error.
        @(negedge clk) spur = 1'b1;
        @(negedge clk) spur = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", err_o, 1'b1);

        // Asynchronous reset in the middle of traffic.
        run_traffic(15, 70, 70, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_traffic(30, 50, 50, 0);
        drain();

`ifdef BLOCK_MEM_ARBITER_STATS_EN
        apply_reset();
        rand_lat = 1'b0;
        lat = 1;
        run_traffic(70000, 100, 0, 0);
        drain();
        chk("stat0_saturated", stat0_o, 16'hFFFF);
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr", {stat0_o, stat1_o}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        errors++;
        $display("FAIL watchdog: time limit reached, got %0t expected finish earlier", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
